// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

   localparam int ADDR_W = 16;
   localparam int INSN_W = 16;

   localparam logic [ADDR_W-1:0] RESET_VEC = 16'h0000;

   typedef enum logic [2:0] {
      ST_CLR    = 3'd0,
      ST_SETTLE = 3'd1,
      ST_REQ    = 3'd2,
      ST_HOLD   = 3'd3,
      ST_IDLE   = 3'd4,
      ST_ERR    = 3'd5
   } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// Fetch controller bus: PC strobes, ROM read port, decoder handshake and control inputs.
interface fetch_if;
   import fetch_pkg::*;

   logic [ADDR_W-1:0] pc_addr;
   logic              pc_load;
   logic              pc_inc;
   logic [ADDR_W-1:0] ins_addr;
   logic              rom_req;
   logic [ADDR_W-1:0] rom_addr;
   logic              rom_ack;
   logic [INSN_W-1:0] rom_data;
   logic [INSN_W-1:0] ir;
   logic              ir_valid;
   logic              ir_ready;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_addr;
   logic              halt;
   logic              fetch_err;

   modport master (
      input  pc_addr, rom_ack, rom_data, ir_ready, redirect, redirect_addr, halt,
      output pc_load, pc_inc, ins_addr, rom_req, rom_addr, ir, ir_valid, fetch_err
   );

   modport slave (
      output pc_addr, rom_ack, rom_data, ir_ready, redirect, redirect_addr, halt,
      input  pc_load, pc_inc, ins_addr, rom_req, rom_addr, ir, ir_valid, fetch_err
   );

endinterface

// File: rtl/fetch_wdog.sv
// ROM request watchdog: flags expiry after TIMEOUT_CYC consecutive cycles of run=1.
module fetch_wdog #(
   parameter int TIMEOUT_CYC = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic expired
);

   localparam int W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

   logic [W-1:0] cnt_r;

   assign expired = run && (cnt_r == LAST);

   // Count stalled request cycles; any gap in run restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= {W{1'b0}};
      end else if (!run) begin
         cnt_r <= {W{1'b0}};
      end else if (!expired) begin
         cnt_r <= cnt_r + W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: clears the PC, lets it settle, reads the ROM and hands words to the decoder.
// Optional ROM watchdog (sticky fetch_err, ERR state) is built when FETCH_TIMEOUT_EN is defined.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int SETTLE_CYC  = 2,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic    clk,
   input  logic    rst,
   fetch_if.master bus
);

   localparam int CNT_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC);

   fetch_state_e      state_r, state_nxt_s;
   logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
   logic              pc_load_r, pc_load_nxt_s;
   logic              pc_inc_r, pc_inc_nxt_s;
   logic [ADDR_W-1:0] ins_addr_r, ins_addr_nxt_s;
   logic              rom_req_r, rom_req_nxt_s;
   logic [ADDR_W-1:0] rom_addr_r, rom_addr_nxt_s;
   logic [INSN_W-1:0] ir_r, ir_nxt_s;
   logic              ir_valid_r, ir_valid_nxt_s;
   logic              pend_r, pend_nxt_s;
   logic [ADDR_W-1:0] pend_addr_r, pend_addr_nxt_s;
   logic              load_now_s;
   logic [ADDR_W-1:0] load_tgt_s;

`ifdef FETCH_TIMEOUT_EN
   logic err_r, err_nxt_s;
   logic wdog_exp_s;

   fetch_wdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .run     (rom_req_r & ~bus.rom_ack),
      .expired (wdog_exp_s)
   );

   assign bus.fetch_err = err_r;
`else
   assign bus.fetch_err = 1'b0;
`endif

   // A live redirect overrides a target latched earlier.
   assign load_now_s = bus.redirect | pend_r;
   assign load_tgt_s = bus.redirect ? bus.redirect_addr : pend_addr_r;

   assign bus.pc_load  = pc_load_r;
   assign bus.pc_inc   = pc_inc_r;
   assign bus.ins_addr = ins_addr_r;
   assign bus.rom_req  = rom_req_r;
   assign bus.rom_addr = rom_addr_r;
   assign bus.ir       = ir_r;
   // A redirect withdraws the held word in the cycle it arrives so the decoder cannot take it.
   assign bus.ir_valid = ir_valid_r & ~bus.redirect;

   // Next-state and next-output decode.
   always_comb begin
      state_nxt_s     = state_r;
      cnt_nxt_s       = cnt_r;
      pc_load_nxt_s   = 1'b0;
      pc_inc_nxt_s    = 1'b0;
      ins_addr_nxt_s  = ins_addr_r;
      rom_req_nxt_s   = rom_req_r;
      rom_addr_nxt_s  = rom_addr_r;
      ir_nxt_s        = ir_r;
      ir_valid_nxt_s  = ir_valid_r;
      pend_nxt_s      = pend_r;
      pend_addr_nxt_s = pend_addr_r;
`ifdef FETCH_TIMEOUT_EN
      err_nxt_s       = err_r;
`endif
      case (state_r)
         ST_CLR: begin
            pc_load_nxt_s  = 1'b1;
            pc_inc_nxt_s   = 1'b1;
            ins_addr_nxt_s = RESET_VEC;
            cnt_nxt_s      = {CNT_W{1'b0}};
            state_nxt_s    = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (load_now_s) begin
               cnt_nxt_s = {CNT_W{1'b0}};
               // Keep pc_load a single-cycle pulse: defer a load that lands on one in flight.
               if (pc_load_r) begin
                  pend_nxt_s      = 1'b1;
                  pend_addr_nxt_s = load_tgt_s;
               end else begin
                  pc_load_nxt_s  = 1'b1;
                  ins_addr_nxt_s = load_tgt_s;
                  pend_nxt_s     = 1'b0;
               end
            end else if (cnt_r == SETTLE_LAST) begin
               cnt_nxt_s = {CNT_W{1'b0}};
               if (bus.halt) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s    = ST_REQ;
                  rom_req_nxt_s  = 1'b1;
                  rom_addr_nxt_s = bus.pc_addr;
               end
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end
         ST_REQ: begin
            if (bus.rom_ack) begin
               rom_req_nxt_s = 1'b0;
               if (load_now_s) begin
                  pc_load_nxt_s  = 1'b1;
                  ins_addr_nxt_s = load_tgt_s;
                  pend_nxt_s     = 1'b0;
                  cnt_nxt_s      = {CNT_W{1'b0}};
                  state_nxt_s    = ST_SETTLE;
               end else begin
                  ir_nxt_s       = bus.rom_data;
                  ir_valid_nxt_s = 1'b1;
                  state_nxt_s    = ST_HOLD;
               end
            end
`ifdef FETCH_TIMEOUT_EN
            else if (wdog_exp_s) begin
               rom_req_nxt_s = 1'b0;
               err_nxt_s     = 1'b1;
               pend_nxt_s    = 1'b0;
               state_nxt_s   = ST_ERR;
            end
`endif
            else if (bus.redirect) begin
               pend_nxt_s      = 1'b1;
               pend_addr_nxt_s = bus.redirect_addr;
            end else begin
               pend_nxt_s = pend_r;
            end
         end
         ST_HOLD: begin
            if (bus.redirect) begin
               pc_load_nxt_s  = 1'b1;
               ins_addr_nxt_s = bus.redirect_addr;
               ir_valid_nxt_s = 1'b0;
               cnt_nxt_s      = {CNT_W{1'b0}};
               state_nxt_s    = ST_SETTLE;
            end else if (bus.ir_ready) begin
               pc_inc_nxt_s   = 1'b1;
               ir_valid_nxt_s = 1'b0;
               cnt_nxt_s      = {CNT_W{1'b0}};
               state_nxt_s    = ST_SETTLE;
            end else begin
               ir_valid_nxt_s = 1'b1;
            end
         end
         ST_IDLE: begin
            if (load_now_s) begin
               pc_load_nxt_s  = 1'b1;
               ins_addr_nxt_s = load_tgt_s;
               pend_nxt_s     = 1'b0;
               cnt_nxt_s      = {CNT_W{1'b0}};
               state_nxt_s    = ST_SETTLE;
            end else if (!bus.halt) begin
               state_nxt_s    = ST_REQ;
               rom_req_nxt_s  = 1'b1;
               rom_addr_nxt_s = bus.pc_addr;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ERR: begin
            rom_req_nxt_s = 1'b0;
            state_nxt_s   = ST_ERR;
         end
         default: begin
            rom_req_nxt_s  = 1'b0;
            ir_valid_nxt_s = 1'b0;
            state_nxt_s    = ST_CLR;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_CLR;
         cnt_r       <= {CNT_W{1'b0}};
         pc_load_r   <= 1'b0;
         pc_inc_r    <= 1'b0;
         ins_addr_r  <= RESET_VEC;
         rom_req_r   <= 1'b0;
         rom_addr_r  <= RESET_VEC;
         ir_r        <= {INSN_W{1'b0}};
         ir_valid_r  <= 1'b0;
         pend_r      <= 1'b0;
         pend_addr_r <= RESET_VEC;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         pc_load_r   <= pc_load_nxt_s;
         pc_inc_r    <= pc_inc_nxt_s;
         ins_addr_r  <= ins_addr_nxt_s;
         rom_req_r   <= rom_req_nxt_s;
         rom_addr_r  <= rom_addr_nxt_s;
         ir_r        <= ir_nxt_s;
         ir_valid_r  <= ir_valid_nxt_s;
         pend_r      <= pend_nxt_s;
         pend_addr_r <= pend_addr_nxt_s;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_r <= 1'b0;
      end else begin
         err_r <= err_nxt_s;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a PC model, a variable-latency ROM and strobe monitors.
module tb_fetch_ctrl;

   logic clk;
   logic rst;
   fetch_if bus ();

   fetch_ctrl #(
      .SETTLE_CYC  (2),
      .TIMEOUT_CYC (15)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   int n_clr  = 0;
   int n_inc  = 0;
   int n_load = 0;
   int n_irv  = 0;
   int n_long = 0;
   int lat    = 1;
   int wcnt   = 0;
   logic [15:0] last_load = 16'h0000;
   logic [15:0] req_q[$];
   logic [15:0] acc_q[$];
   logic prev_ld  = 1'b0;
   logic prev_inc = 1'b0;
   logic prev_req = 1'b0;
   logic [15:0] pc = 16'h0000;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] rom_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'hC3A5;
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(input int n0, input string tag);
      for (int i = 0; i < 40; i++) begin
         if (req_q.size() > n0) break;
         step();
      end
      chk(tag, 32'(req_q.size() > n0), 32'd1);
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 40; i++) begin
         if (bus.ir_valid === 1'b1) break;
         step();
      end
      chk(tag, 32'(bus.ir_valid), 32'd1);
   endtask

   // PC model: strobes seen during a cycle take effect just after the next rising edge.
   initial begin
      logic ld, inc;
      logic [15:0] tgt;
      bus.pc_addr = 16'h0000;
      forever begin
         @(negedge clk);
         ld  = bus.pc_load;
         inc = bus.pc_inc;
         tgt = bus.ins_addr;
         @(posedge clk);
         #1;
         if (rst) pc = 16'h0000;
         else if (ld && inc) pc = 16'h0000;
         else if (ld) pc = tgt;
         else if (inc) pc = pc + 16'h0001;
         bus.pc_addr = pc;
      end
   end

   // ROM responder at the falling edge, then a monitor just before the next rising edge.
   initial begin
      bus.rom_ack  = 1'b0;
      bus.rom_data = 16'h0000;
      forever begin
         @(negedge clk);
         if (rst || !bus.rom_req || bus.rom_ack) begin
            bus.rom_ack = 1'b0;
            wcnt = 0;
         end else if (wcnt + 1 >= lat) begin
            bus.rom_ack  = 1'b1;
            bus.rom_data = rom_word(bus.rom_addr);
         end else begin
            wcnt++;
         end
         #4;
         if (bus.pc_load && bus.pc_inc) n_clr++;
         else begin
            if (bus.pc_load) begin n_load++; last_load = bus.ins_addr; end
            if (bus.pc_inc) n_inc++;
         end
         if ((bus.pc_load && prev_ld) || (bus.pc_inc && prev_inc)) n_long++;
         prev_ld  = bus.pc_load;
         prev_inc = bus.pc_inc;
         if (bus.ir_valid) n_irv++;
         if (bus.ir_valid && bus.ir_ready) acc_q.push_back(bus.ir);
         if (bus.rom_req && !prev_req) req_q.push_back(bus.rom_addr);
         prev_req = bus.rom_req;
      end
   end

   initial begin
      #400000;
      $display("FAIL global_time_limit checks=%0d", checks);
      $fatal(1, "time limit reached");
   end

   initial begin
      int n0, inc0, ld0, irv0, clr0;
      rst               = 1'b1;
      bus.ir_ready      = 1'b0;
      bus.redirect      = 1'b0;
      bus.redirect_addr = 16'h0000;
      bus.halt          = 1'b0;
      repeat (3) step();

      chk("rst_pc_load",   32'(bus.pc_load),   32'd0);
      chk("rst_pc_inc",    32'(bus.pc_inc),    32'd0);
      chk("rst_rom_req",   32'(bus.rom_req),   32'd0);
      chk("rst_ir_valid",  32'(bus.ir_valid),  32'd0);
      chk("rst_fetch_err", 32'(bus.fetch_err), 32'd0);
      chk("rst_ir",        32'(bus.ir),        32'h0000);
      chk("rst_ins_addr",  32'(bus.ins_addr),  32'h0000);
      chk("rst_rom_addr",  32'(bus.rom_addr),  32'h0000);

      // Sequential fetch, 1-cycle ROM, decoder always ready.
      rst = 1'b0;
      bus.ir_ready = 1'b1;
      for (int i = 0; i < 80; i++) begin
         if (acc_q.size() >= 3) break;
         step();
      end
      chk("seq_accepts", 32'(acc_q.size() >= 3), 32'd1);
      step();
      bus.ir_ready = 1'b0;
      chk("seq_clr_pulse", 32'(n_clr), 32'd1);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("seq_rom_addr%0d", i), 32'(req_q[i]), 32'(i));
         chk($sformatf("seq_ir%0d", i), 32'(acc_q[i]), 32'(rom_word(16'(i))));
      end

      // Decoder stall on word 3.
      wait_valid("stall_wait_valid");
      for (int i = 0; i < 10; i++) begin
         step();
         chk("stall_ir_valid", 32'(bus.ir_valid), 32'd1);
         chk("stall_ir", 32'(bus.ir), 32'(rom_word(16'h0003)));
      end
      inc0 = n_inc;
      bus.ir_ready = 1'b1;
      step();
      bus.ir_ready = 1'b0;
      repeat (3) step();
      chk("stall_one_inc", 32'(n_inc), 32'(inc0 + 1));
      chk("stall_accept_word", 32'(acc_q[acc_q.size()-1]), 32'(rom_word(16'h0003)));

      // Redirect in HOLD together with ir_ready.
      wait_valid("redir_wait_valid");
      inc0 = n_inc;
      ld0  = n_load;
      n0   = req_q.size();
      bus.redirect      = 1'b1;
      bus.redirect_addr = 16'h00A0;
      bus.ir_ready      = 1'b1;
      #1;
      chk("redir_drop_valid", 32'(bus.ir_valid), 32'd0);
      step();
      bus.redirect = 1'b0;
      bus.ir_ready = 1'b0;
      chk("redir_pc_load", 32'(bus.pc_load), 32'd1);
      chk("redir_ins_addr", 32'(bus.ins_addr), 32'h00A0);
      chk("redir_no_inc_now", 32'(bus.pc_inc), 32'd0);
      repeat (2) step();
      chk("redir_inc_count", 32'(n_inc), 32'(inc0));
      chk("redir_load_count", 32'(n_load), 32'(ld0 + 1));
      wait_req(n0, "redir_wait_req");
      chk("redir_rom_addr", 32'(req_q[req_q.size()-1]), 32'h00A0);
      wait_valid("redir_wait_word");
      chk("redir_ir", 32'(bus.ir), 32'(rom_word(16'h00A0)));

      // Two redirects during a 5-cycle ROM read: last target wins, word discarded.
      lat = 5;
      n0  = req_q.size();
      bus.ir_ready = 1'b1;
      step();
      bus.ir_ready = 1'b0;
      wait_req(n0, "late_wait_req");
      chk("late_rom_addr", 32'(req_q[req_q.size()-1]), 32'h00A1);
      ld0  = n_load;
      irv0 = n_irv;
      n0   = req_q.size();
      bus.redirect = 1'b1; bus.redirect_addr = 16'h0040;
      step();
      bus.redirect = 1'b0;
      step();
      bus.redirect = 1'b1; bus.redirect_addr = 16'h0050;
      step();
      bus.redirect = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (bus.pc_load === 1'b1) break;
         step();
      end
      chk("late_pc_load", 32'(bus.pc_load), 32'd1);
      chk("late_ins_addr", 32'(bus.ins_addr), 32'h0050);
      repeat (2) step();
      chk("late_load_count", 32'(n_load), 32'(ld0 + 1));
      chk("late_last_load", 32'(last_load), 32'h0050);
      chk("late_no_valid", 32'(n_irv), 32'(irv0));
      chk("late_ir_kept", 32'(bus.ir), 32'(rom_word(16'h00A0)));
      wait_req(n0, "late_wait_req2");
      chk("late_rom_addr2", 32'(req_q[req_q.size()-1]), 32'h0050);
      wait_valid("late_wait_word");
      chk("late_ir", 32'(bus.ir), 32'(rom_word(16'h0050)));

      // PC wrap from 0xFFFF.
      lat = 1;
      n0  = req_q.size();
      bus.redirect = 1'b1; bus.redirect_addr = 16'hFFFF;
      step();
      bus.redirect = 1'b0;
      wait_req(n0, "wrap_wait_req");
      chk("wrap_rom_addr_ffff", 32'(req_q[req_q.size()-1]), 32'hFFFF);
      wait_valid("wrap_wait_word");
      chk("wrap_ir", 32'(bus.ir), 32'(rom_word(16'hFFFF)));
      n0 = req_q.size();
      bus.ir_ready = 1'b1;
      step();
      bus.ir_ready = 1'b0;
      wait_req(n0, "wrap_wait_req2");
      chk("wrap_rom_addr_0000", 32'(req_q[req_q.size()-1]), 32'h0000);

      // Halt into IDLE, redirect while idle, then resume.
      wait_valid("halt_wait_word");
      bus.halt     = 1'b1;
      bus.ir_ready = 1'b1;
      step();
      bus.ir_ready = 1'b0;
      n0 = req_q.size();
      repeat (8) step();
      chk("idle_rom_req", 32'(bus.rom_req), 32'd0);
      chk("idle_no_req", 32'(req_q.size()), 32'(n0));
      bus.redirect = 1'b1; bus.redirect_addr = 16'h0123;
      step();
      bus.redirect = 1'b0;
      chk("idle_pc_load", 32'(bus.pc_load), 32'd1);
      chk("idle_ins_addr", 32'(bus.ins_addr), 32'h0123);
      repeat (6) step();
      chk("idle_still_parked", 32'(bus.rom_req), 32'd0);
      lat = 100000;
      bus.halt = 1'b0;
      wait_req(n0, "resume_wait_req");
      chk("resume_rom_addr", 32'(req_q[req_q.size()-1]), 32'h0123);

`ifdef FETCH_TIMEOUT_EN
      repeat (13) step();
      chk("tmo_err_before", 32'(bus.fetch_err), 32'd0);
      chk("tmo_req_before", 32'(bus.rom_req), 32'd1);
      step();
      chk("tmo_err_set", 32'(bus.fetch_err), 32'd1);
      chk("tmo_req_drop", 32'(bus.rom_req), 32'd0);
      repeat (5) step();
      chk("tmo_err_sticky", 32'(bus.fetch_err), 32'd1);
      rst = 1'b1;
      #1;
      chk("tmo_err_cleared", 32'(bus.fetch_err), 32'd0);
`else
      repeat (30) step();
      chk("notmo_req_held", 32'(bus.rom_req), 32'd1);
      chk("notmo_err_zero", 32'(bus.fetch_err), 32'd0);
      rst = 1'b1;
      #1;
`endif
      chk("rst_req_abandon", 32'(bus.rom_req), 32'd0);
      step();
      clr0 = n_clr;
      n0   = req_q.size();
      rst  = 1'b0;
      wait_req(n0, "rerun_wait_req");
      chk("rerun_rom_addr", 32'(req_q[req_q.size()-1]), 32'h0000);
      chk("rerun_clr_pulse", 32'(n_clr), 32'(clr0 + 1));
      repeat (2) step();
      rst = 1'b1;
      #1;
      chk("midfetch_req_drop", 32'(bus.rom_req), 32'd0);
      chk("midfetch_ir_valid", 32'(bus.ir_valid), 32'd0);
      step();
      rst = 1'b0;
      repeat (3) step();
      chk("midfetch_clr_pulse", 32'(n_clr), 32'(clr0 + 2));
      chk("strobe_single_cycle", 32'(n_long), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
